recfg_sequencer: RTL and testbench
==================================

RECFG_SEQUENCER -- requirements
Module: recfg_sequencer

Interface
REQ-001 SHALL have parameter HOLDOFF_CYCLES, default 1000, meaning clk cycles between an accepted trigger and the recfg pulse; legal range 1..2^24-1.
REQ-002 SHALL have parameter PULSE_CYCLES, default 16, meaning recfg pulse width in clk cycles; legal range 1..255.
REQ-003 SHALL have port clk  in  1  single clock; every register samples on its rising edge.
REQ-004 SHALL have port rst  in  1  reset, asynchronous and active-high.
REQ-005 SHALL have port s_data  in  8  configuration byte.
REQ-006 SHALL have port s_valid  in  1  s_data is valid.
REQ-007 SHALL have port s_last  in  1  s_data is the final byte of the stream.
REQ-008 SHALL have port s_ready  out  1  a byte is accepted on a cycle where s_valid and s_ready are both 1.
REQ-009 SHALL have port trig  in  1  reconfiguration request, level-sampled.
REQ-010 SHALL have port busy  out  1  high in every state except IDLE.
REQ-011 SHALL have port cfg_clk  out  1  byte clock to the configuration controller.
REQ-012 SHALL have port cfg_en  out  1  configuration-controller enable.
REQ-013 SHALL have port cfg_data  out  8  byte to the configuration controller.
REQ-014 SHALL have port cfg_valid  out  1  cfg_data is valid.
REQ-015 SHALL have port cfg_recfg  out  1  reconfiguration trigger to the configuration controller.

Function
REQ-016 SHALL implement the states IDLE, SETUP, STROBE, WAIT, HOLDOFF and PULSE; all outputs SHALL be registered.
REQ-017 IDLE: s_ready=1. An s_valid handshake SHALL capture s_data and s_last and move to SETUP. Otherwise trig=1 SHALL move to HOLDOFF. If both occur in the same cycle, the handshake SHALL win and trig SHALL be ignored.
REQ-018 SETUP (1 cycle): cfg_en=1, cfg_valid=1, cfg_data=captured byte, cfg_clk=0; then STROBE.
REQ-019 STROBE (1 cycle): cfg_clk=1 with cfg_data and cfg_valid held; then clear cfg_valid. If the captured s_last=1, go to IDLE and drop cfg_en. Otherwise go to WAIT.
REQ-020 WAIT: cfg_en=1, cfg_clk=0, s_ready=1. A handshake SHALL capture the byte and move to SETUP. Therefore the sustained rate is 1 byte per 3 cycles, with 2 cycles from handshake to cfg_clk rising.
REQ-021 trig SHALL be ignored in SETUP, STROBE and WAIT, and SHALL NOT be queued.
REQ-022 HOLDOFF: a 24-bit counter SHALL load 0 on entry and increment each cycle; when it reaches HOLDOFF_CYCLES-1, go to PULSE. trig and s_valid SHALL be ignored (s_ready=0).
REQ-023 PULSE: cfg_recfg=1 for exactly PULSE_CYCLES cycles, using an 8-bit counter; then go to IDLE with cfg_recfg=0.
REQ-024 Latency: trig sampled in IDLE at cycle T SHALL give cfg_recfg=1 first at cycle T+1+HOLDOFF_CYCLES.
REQ-025 s_ready SHALL be 0 in SETUP, STROBE, HOLDOFF and PULSE.
REQ-026 Counters SHALL NOT wrap. Values of HOLDOFF_CYCLES and PULSE_CYCLES outside their legal range SHALL be rejected at elaboration.

Reset
REQ-027 rst=1 SHALL force, asynchronously, state=IDLE, both counters=0, and cfg_clk, cfg_en, cfg_valid, cfg_recfg, cfg_data=0, busy=0, s_ready=0.
REQ-028 s_ready SHALL rise on the first clk edge after rst deasserts.
REQ-029 Reset in any state, including mid-PULSE, SHALL drop cfg_recfg immediately and discard the captured byte.

Structure
REQ-030 A shared package recfg_pkg SHALL hold the state enum, CFG_BYTE_W=8, HOLDOFF_W=24 and PULSE_W=8.
REQ-031 The HOLDOFF and PULSE counters SHALL be one reusable sub-module, recfg_timer (load/start, terminal-count flag), instantiated twice.

Verification
REQ-032 The bench SHALL cover the reset and idle state: rst pulse mid-PULSE -> cfg_recfg=0 in the same cycle, then s_ready=1 one cycle after release.
REQ-033 The bench SHALL cover a 3-byte stream: bytes 0xA5, 0x3C, 0xFF (last) with s_valid held -> cfg_clk rises 3 times with cfg_data matching each byte, cfg_en=1 throughout, cfg_en=0 one cycle after the last STROBE.
REQ-034 The bench SHALL cover a basic trigger: HOLDOFF_CYCLES=5, PULSE_CYCLES=3, trig at cycle 10 -> cfg_recfg high in cycles 16..18, busy=0 at cycle 19.
REQ-035 The bench SHALL cover the ignore rules: trig asserted during a stream and during HOLDOFF -> no second pulse, and the pulse timing is unchanged.
REQ-036 The bench SHALL cover the simultaneous case: s_valid=1 and trig=1 in the same IDLE cycle -> the byte is streamed and no cfg_recfg pulse occurs.
REQ-037 The bench SHALL cover the limits: HOLDOFF_CYCLES=1, PULSE_CYCLES=1, trig at T -> cfg_recfg=1 only at T+2.

Source files
------------

// File: rtl/recfg_pkg.sv
// Shared definitions for the reconfiguration sequencer.
//   CFG_BYTE_W : width of a configuration byte
//   HOLDOFF_W  : width of the trigger-to-pulse holdoff counter
//   PULSE_W    : width of the recfg pulse-width counter
//   state_e    : sequencer FSM states
package recfg_pkg;

  localparam int unsigned CFG_BYTE_W = 8;
  localparam int unsigned HOLDOFF_W  = 24;
  localparam int unsigned PULSE_W    = 8;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_SETUP   = 3'd1,
    ST_STROBE  = 3'd2,
    ST_WAIT    = 3'd3,
    ST_HOLDOFF = 3'd4,
    ST_PULSE   = 3'd5
  } state_e;

endpackage

// File: rtl/recfg_sequencer_if.sv
// Byte-stream handshake into the reconfiguration sequencer.
//   s_data  : configuration byte
//   s_valid : s_data is valid
//   s_last  : s_data is the final byte of the stream
//   s_ready : sequencer accepts a byte when s_valid && s_ready
// master = byte source, slave = sequencer.
interface recfg_sequencer_if;

  logic [recfg_pkg::CFG_BYTE_W-1:0] s_data;
  logic                             s_valid;
  logic                             s_last;
  logic                             s_ready;

  modport master (
    output s_data,
    output s_valid,
    output s_last,
    input  s_ready
  );

  modport slave (
    input  s_data,
    input  s_valid,
    input  s_last,
    output s_ready
  );

endinterface

// File: rtl/recfg_timer.sv
// Saturating up-counter with a terminal-count flag.
//   clk, rst : clock, asynchronous active-high reset (count -> 0)
//   load     : force the count to 0 (takes priority over en)
//   en       : increment by one; holds once TERMINAL is reached
//   tc       : count equals TERMINAL
module recfg_timer #(
  parameter int unsigned     W        = 8,
  parameter logic [W-1:0]    TERMINAL = '0
) (
  input  logic clk,
  input  logic rst,
  input  logic load,
  input  logic en,
  output logic tc
);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  assign tc = (cnt_q == TERMINAL);

  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = '0;
    end else if (en && !tc) begin
      cnt_d = cnt_q + W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/recfg_sequencer.sv
// Reconfiguration sequencer: streams configuration bytes to a configuration
// controller (one byte per three clocks, setup then strobe) and, on request,
// issues a delayed reconfiguration pulse.
//   clk, rst   : clock, asynchronous active-high reset
//   s          : byte-stream slave (s_data/s_valid/s_last/s_ready)
//   trig       : reconfiguration request, sampled in IDLE only
//   busy       : high whenever not IDLE
//   cfg_clk    : byte clock, high for the strobe cycle
//   cfg_en     : controller enable for the whole stream
//   cfg_data   : byte presented to the controller
//   cfg_valid  : cfg_data valid (setup and strobe cycles)
//   cfg_recfg  : reconfiguration pulse, PULSE_CYCLES wide
// All outputs are registered: they are decoded from the next state and
// captured with the state register.
module recfg_sequencer
  import recfg_pkg::*;
#(
  parameter int unsigned HOLDOFF_CYCLES = 1000,
  parameter int unsigned PULSE_CYCLES   = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  recfg_sequencer_if.slave      s,
  input  logic                  trig,
  output logic                  busy,
  output logic                  cfg_clk,
  output logic                  cfg_en,
  output logic [CFG_BYTE_W-1:0] cfg_data,
  output logic                  cfg_valid,
  output logic                  cfg_recfg
);

  if (HOLDOFF_CYCLES == 0 || HOLDOFF_CYCLES > (32'd1 << HOLDOFF_W) - 32'd1) begin : g_bad_holdoff
    $fatal(1, "recfg_sequencer: HOLDOFF_CYCLES out of range 1..2^24-1");
  end
  if (PULSE_CYCLES == 0 || PULSE_CYCLES > (32'd1 << PULSE_W) - 32'd1) begin : g_bad_pulse
    $fatal(1, "recfg_sequencer: PULSE_CYCLES out of range 1..255");
  end

  localparam logic [HOLDOFF_W-1:0] HOLD_TC  = HOLDOFF_W'(HOLDOFF_CYCLES - 1);
  localparam logic [PULSE_W-1:0]   PULSE_TC = PULSE_W'(PULSE_CYCLES - 1);

  state_e                  state_q,     state_d;
  logic [CFG_BYTE_W-1:0]   byte_q,      byte_d;
  logic                    last_q,      last_d;
  logic                    busy_q,      busy_d;
  logic                    s_ready_q,   s_ready_d;
  logic                    cfg_clk_q,   cfg_clk_d;
  logic                    cfg_en_q,    cfg_en_d;
  logic [CFG_BYTE_W-1:0]   cfg_data_q,  cfg_data_d;
  logic                    cfg_valid_q, cfg_valid_d;
  logic                    cfg_recfg_q, cfg_recfg_d;

  logic hs;
  logic hold_tc;
  logic pulse_tc;

  assign hs = s.s_valid && s_ready_q;

  // Each timer is held at zero outside its own state, so it starts from 0
  // on the first cycle of that state.
  recfg_timer #(
    .W        (HOLDOFF_W),
    .TERMINAL (HOLD_TC)
  ) u_holdoff_timer (
    .clk  (clk),
    .rst  (rst),
    .load (state_q != ST_HOLDOFF),
    .en   (state_q == ST_HOLDOFF),
    .tc   (hold_tc)
  );

  recfg_timer #(
    .W        (PULSE_W),
    .TERMINAL (PULSE_TC)
  ) u_pulse_timer (
    .clk  (clk),
    .rst  (rst),
    .load (state_q != ST_PULSE),
    .en   (state_q == ST_PULSE),
    .tc   (pulse_tc)
  );

  always_comb begin
    state_d = state_q;
    byte_d  = byte_q;
    last_d  = last_q;

    case (state_q)
      ST_IDLE: begin
        // A byte handshake takes precedence over a simultaneous trig.
        if (hs) begin
          byte_d  = s.s_data;
          last_d  = s.s_last;
          state_d = ST_SETUP;
        end else if (trig) begin
          state_d = ST_HOLDOFF;
        end
      end
      ST_SETUP: state_d = ST_STROBE;
      ST_STROBE: state_d = last_q ? ST_IDLE : ST_WAIT;
      ST_WAIT: begin
        if (hs) begin
          byte_d  = s.s_data;
          last_d  = s.s_last;
          state_d = ST_SETUP;
        end
      end
      ST_HOLDOFF: if (hold_tc) state_d = ST_PULSE;
      ST_PULSE: if (pulse_tc) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase

    busy_d      = (state_d != ST_IDLE);
    s_ready_d   = (state_d == ST_IDLE) || (state_d == ST_WAIT);
    cfg_en_d    = (state_d == ST_SETUP) || (state_d == ST_STROBE) || (state_d == ST_WAIT);
    cfg_valid_d = (state_d == ST_SETUP) || (state_d == ST_STROBE);
    cfg_clk_d   = (state_d == ST_STROBE);
    cfg_recfg_d = (state_d == ST_PULSE);
    cfg_data_d  = cfg_valid_d ? byte_d : '0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      byte_q      <= '0;
      last_q      <= 1'b0;
      busy_q      <= 1'b0;
      s_ready_q   <= 1'b0;
      cfg_clk_q   <= 1'b0;
      cfg_en_q    <= 1'b0;
      cfg_data_q  <= '0;
      cfg_valid_q <= 1'b0;
      cfg_recfg_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      byte_q      <= byte_d;
      last_q      <= last_d;
      busy_q      <= busy_d;
      s_ready_q   <= s_ready_d;
      cfg_clk_q   <= cfg_clk_d;
      cfg_en_q    <= cfg_en_d;
      cfg_data_q  <= cfg_data_d;
      cfg_valid_q <= cfg_valid_d;
      cfg_recfg_q <= cfg_recfg_d;
    end
  end

  assign s.s_ready = s_ready_q;
  assign busy      = busy_q;
  assign cfg_clk   = cfg_clk_q;
  assign cfg_en    = cfg_en_q;
  assign cfg_data  = cfg_data_q;
  assign cfg_valid = cfg_valid_q;
  assign cfg_recfg = cfg_recfg_q;

endmodule

// File: tb/tb_recfg_sequencer.sv
// Self-checking bench for recfg_sequencer. Two instances: one with
// HOLDOFF_CYCLES=5/PULSE_CYCLES=3, one at the minimum 1/1 limits.
// Cycle n is the interval following the n-th rising clk edge.
module tb_recfg_sequencer;

  localparam int unsigned H = 5;
  localparam int unsigned P = 3;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       trig = 1'b0;
  logic       busy, cfg_clk, cfg_en, cfg_valid, cfg_recfg;
  logic [7:0] cfg_data;
  logic       trig2 = 1'b0;
  logic       busy2, cfg_clk2, cfg_en2, cfg_valid2, cfg_recfg2;
  logic [7:0] cfg_data2;

  always #5 clk = ~clk;

  recfg_sequencer_if sif ();
  recfg_sequencer_if sif2 ();

  recfg_sequencer #(.HOLDOFF_CYCLES(H), .PULSE_CYCLES(P)) dut (
    .clk(clk), .rst(rst), .s(sif), .trig(trig), .busy(busy),
    .cfg_clk(cfg_clk), .cfg_en(cfg_en), .cfg_data(cfg_data),
    .cfg_valid(cfg_valid), .cfg_recfg(cfg_recfg)
  );

  recfg_sequencer #(.HOLDOFF_CYCLES(1), .PULSE_CYCLES(1)) dut_lim (
    .clk(clk), .rst(rst), .s(sif2), .trig(trig2), .busy(busy2),
    .cfg_clk(cfg_clk2), .cfg_en(cfg_en2), .cfg_data(cfg_data2),
    .cfg_valid(cfg_valid2), .cfg_recfg(cfg_recfg2)
  );

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;
  int unsigned cyc = 0;

  logic [7:0]  byte_q[$];
  int unsigned pulse_q[$];
  int unsigned en_q[$];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, act, exp, cyc);
    end
  endtask

  task automatic goto(input int unsigned n);
    while (cyc < n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic step(input int unsigned n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Presents one byte and holds it until the handshake edge; returns just
  // after that edge with s_valid still asserted.
  task automatic send_byte(input logic [7:0] data, input logic last);
    bit got = 1'b0;
    sif.s_data  = data;
    sif.s_last  = last;
    sif.s_valid = 1'b1;
    for (int i = 0; i < 40 && !got; i++) begin
      @(negedge clk);
      if (sif.s_ready === 1'b1) begin
        byte_q.push_back(data);
        got = 1'b1;
      end
    end
    if (!got) check_val("hs_timeout", 32'(got), 32'd1);
    @(posedge clk);
    #1;
  endtask

  // Output monitor: pops expected strobe bytes, pulse start cycles and
  // cfg_en run lengths as the DUT produces them.
  logic        rec_prev = 1'b0, clk_prev = 1'b0, en_prev = 1'b0;
  bit          rec_active = 1'b0;
  int unsigned rec_width = 0;
  int unsigned en_run = 0;

  always @(negedge clk) begin
    if (rst) begin
      rec_prev   = 1'b0;
      clk_prev   = 1'b0;
      en_prev    = 1'b0;
      rec_active = 1'b0;
      en_run     = 0;
    end else begin
      if (cfg_recfg && !rec_prev) begin
        check_val("recfg_expected", 32'(pulse_q.size() != 0), 32'd1);
        if (pulse_q.size() != 0) check_val("recfg_start", cyc, pulse_q.pop_front());
        rec_active = 1'b1;
        rec_width  = 1;
      end else if (cfg_recfg) begin
        rec_width++;
      end else if (rec_prev && rec_active) begin
        check_val("recfg_width", rec_width, P);
        rec_active = 1'b0;
      end
      rec_prev = cfg_recfg;

      if (cfg_clk && !clk_prev) begin
        check_val("strobe_expected", 32'(byte_q.size() != 0), 32'd1);
        if (byte_q.size() != 0) check_val("strobe_data", 32'(cfg_data), 32'(byte_q.pop_front()));
        check_val("strobe_valid", 32'(cfg_valid), 32'd1);
        check_val("strobe_en", 32'(cfg_en), 32'd1);
      end
      clk_prev = cfg_clk;

      if (cfg_en) begin
        en_run++;
      end else if (en_prev) begin
        check_val("en_expected", 32'(en_q.size() != 0), 32'd1);
        if (en_q.size() != 0) check_val("en_run_len", en_run, en_q.pop_front());
        en_run = 0;
      end
      en_prev = cfg_en;
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int unsigned t0;
    sif.s_data = '0;  sif.s_valid = 1'b0;  sif.s_last = 1'b0;
    sif2.s_data = '0; sif2.s_valid = 1'b0; sif2.s_last = 1'b0;

    // Reset state and release.
    goto(2);
    check_val("rst_busy", 32'(busy), 32'd0);
    check_val("rst_sready", 32'(sif.s_ready), 32'd0);
    check_val("rst_outs", {27'd0, cfg_clk, cfg_en, cfg_valid, cfg_recfg, 1'b0}, 32'd0);
    check_val("rst_data", 32'(cfg_data), 32'd0);
    rst = 1'b0;
    @(negedge clk);
    check_val("rel_sready_lo", 32'(sif.s_ready), 32'd0);
    @(posedge clk); #1;
    check_val("rel_sready_hi", 32'(sif.s_ready), 32'd1);
    check_val("rel_busy", 32'(busy), 32'd0);

    // Basic trigger in cycle 10: pulse in 16..18, idle at 19.
    goto(10);
    trig = 1'b1;
    pulse_q.push_back(cyc + 1 + H);
    goto(11);
    trig = 1'b0;
    goto(18); @(negedge clk);
    check_val("trig_busy18", 32'(busy), 32'd1);
    check_val("trig_recfg18", 32'(cfg_recfg), 32'd1);
    goto(19); @(negedge clk);
    check_val("trig_busy19", 32'(busy), 32'd0);
    check_val("trig_recfg19", 32'(cfg_recfg), 32'd0);

    // Three-byte stream with s_valid held.
    goto(22);
    en_q.push_back(8);
    send_byte(8'hA5, 1'b0);
    send_byte(8'h3C, 1'b0);
    send_byte(8'hFF, 1'b1);
    sif.s_valid = 1'b0;
    sif.s_last  = 1'b0;
    @(negedge clk);
    check_val("last_setup_clk", 32'(cfg_clk), 32'd0);
    check_val("last_setup_valid", 32'(cfg_valid), 32'd1);
    check_val("last_setup_data", 32'(cfg_data), 32'hFF);
    check_val("last_setup_sready", 32'(sif.s_ready), 32'd0);
    @(negedge clk);
    check_val("last_strobe_clk", 32'(cfg_clk), 32'd1);
    @(negedge clk);
    check_val("post_stream_en", 32'(cfg_en), 32'd0);
    check_val("post_stream_valid", 32'(cfg_valid), 32'd0);
    check_val("post_stream_busy", 32'(busy), 32'd0);
    check_val("post_stream_sready", 32'(sif.s_ready), 32'd1);
    step(1);

    // trig during a stream is ignored.
    en_q.push_back(5);
    send_byte(8'h11, 1'b0);
    trig = 1'b1;
    send_byte(8'h22, 1'b1);
    trig = 1'b0;
    sif.s_valid = 1'b0;
    sif.s_last  = 1'b0;
    step(4);

    // trig during HOLDOFF is ignored and does not shift the pulse.
    t0 = cyc;
    trig = 1'b1;
    pulse_q.push_back(t0 + 1 + H);
    step(1); trig = 1'b0;
    step(1); trig = 1'b1;
    step(2); trig = 1'b0;
    step(12);
    check_val("ign_busy", 32'(busy), 32'd0);

    // s_valid and trig in the same IDLE cycle: byte wins, no pulse.
    en_q.push_back(2);
    trig = 1'b1;
    send_byte(8'h5A, 1'b1);
    trig = 1'b0;
    sif.s_valid = 1'b0;
    sif.s_last  = 1'b0;
    step(15);
    check_val("simul_busy", 32'(busy), 32'd0);

    // Reset in the middle of a pulse.
    t0 = cyc;
    trig = 1'b1;
    pulse_q.push_back(t0 + 1 + H);
    step(1); trig = 1'b0;
    goto(t0 + 7);
    check_val("pre_rst_recfg", 32'(cfg_recfg), 32'd1);
    rst = 1'b1;
    #1;
    check_val("mid_rst_recfg", 32'(cfg_recfg), 32'd0);
    check_val("mid_rst_busy", 32'(busy), 32'd0);
    check_val("mid_rst_sready", 32'(sif.s_ready), 32'd0);
    @(posedge clk); #2;
    rst = 1'b0;
    @(negedge clk);
    check_val("mid_rel_sready_lo", 32'(sif.s_ready), 32'd0);
    @(posedge clk); #1;
    check_val("mid_rel_sready_hi", 32'(sif.s_ready), 32'd1);
    check_val("mid_rel_busy", 32'(busy), 32'd0);

    // Minimum limits: trig at T gives a single-cycle pulse at T+2.
    step(2);
    trig2 = 1'b1;
    step(1);
    trig2 = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      check_val("lim_recfg", 32'(cfg_recfg2), 32'(k == 2));
      check_val("lim_busy", 32'(busy2), 32'(k <= 2));
      @(posedge clk); #1;
    end

    step(10);
    check_val("sb_bytes_left", byte_q.size(), 32'd0);
    check_val("sb_pulses_left", pulse_q.size(), 32'd0);
    check_val("sb_en_left", en_q.size(), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
